// File: rtl/jtcop_paldma.sv
// Palette copy engine: copies 2^AW 16-bit words from a CPU shadow buffer into palette RAM during vertical blank.
// Latency: busy rises the edge after trig; the copy starts the edge vblank begins; at least 2 cycles per word.
// Backpressure: src_cs is held and the engine stalls in READ until src_ok; palette writes never stall.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   LVBL              vertical blank, active-low (0 = blanking)
//   trig              single-cycle CPU copy request
//   busy              request pending or copy in progress
//   late              sticky: blanking ended before a copy finished
//   src_addr/src_cs   shadow-buffer read address / read request
//   src_ok/src_dout   shadow-buffer read data valid / data
//   pal_addr/pal_dout palette RAM write address / data
//   pal_we            palette RAM byte write enables
module jtcop_paldma #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LVBL,
    input  logic          trig,
    output logic          busy,
    output logic          late,
    output logic [AW-1:0] src_addr,
    output logic          src_cs,
    input  logic          src_ok,
    input  logic [15:0]   src_dout,
    output logic [AW-1:0] pal_addr,
    output logic [15:0]   pal_dout,
    output logic [1:0]    pal_we
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_READ    = 2'd2,
        ST_WRITE   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nx;
    logic [15:0]   r_dat;
    logic [15:0]   w_dat_nx;
    logic          r_rearm;
    logic          w_rearm_nx;
    logic          r_late;
    logic          w_late_nx;
    logic          r_lvbl_l;
    logic          w_vb_start;
    logic          w_vb_end;
    logic          w_copying;

    assign w_vb_start = r_lvbl_l & ~LVBL;
    assign w_vb_end   = ~r_lvbl_l & LVBL;
    assign w_copying  = (r_state == ST_READ) || (r_state == ST_WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_dat    <= '0;
            r_rearm  <= 1'b0;
            r_late   <= 1'b0;
            r_lvbl_l <= 1'b1;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_dat    <= w_dat_nx;
            r_rearm  <= w_rearm_nx;
            r_late   <= w_late_nx;
            r_lvbl_l <= LVBL;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_dat_nx   = r_dat;
        w_rearm_nx = r_rearm;
        w_late_nx  = r_late;

        // Any number of requests while busy collapse into one extra copy.
        if (trig && (r_state != ST_IDLE)) begin
            w_rearm_nx = 1'b1;
        end

        // A copy that overruns blanking still completes; it is only flagged.
        if (w_copying && w_vb_end) begin
            w_late_nx = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (trig) begin
                    w_state_nx = ST_WAIT_VB;
                    w_late_nx  = 1'b0;
                end
            end
            ST_WAIT_VB: begin
                // Only a fresh blanking edge starts a copy, never the blanking level.
                if (w_vb_start) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_READ;
                end
            end
            ST_READ: begin
                if (src_ok) begin
                    w_dat_nx   = src_dout;
                    w_state_nx = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_cnt_nx = r_cnt + 1'b1;
                if (&r_cnt) begin
                    // A trig landing on the last write counts as a re-arm too.
                    w_state_nx = (r_rearm || trig) ? ST_WAIT_VB : ST_IDLE;
                    w_rearm_nx = 1'b0;
                end else begin
                    w_state_nx = ST_READ;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign late     = r_late;
    assign src_cs   = (r_state == ST_READ);
    assign src_addr = r_cnt;
    assign pal_addr = r_cnt;
    assign pal_dout = r_dat;
    assign pal_we   = (r_state == ST_WRITE) ? 2'b11 : 2'b00;

endmodule
